// File: rtl/udp_lb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udp_lb_pkg
// Purpose  : Shared constants, write-FSM state encoding and entry helpers for
//            the UDP receive loopback (echo) block.
// Contents : DATA_W, MTY_W, ENTRY_W, wr_state_e, entry_width()
// Revision : 1.0 - initial release
// ============================================================================
package udp_lb_pkg;

    localparam int DATA_W  = 16;
    localparam int MTY_W   = 1;
    // One buffer entry is {eop, mty, data}.
    localparam int ENTRY_W = DATA_W + MTY_W + 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RECV = 2'd1,
        W_DROP = 2'd2
    } wr_state_e;

    // Entry width for a non-default payload width.
    function automatic int entry_width(input int data_w);
        return data_w + MTY_W + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_rx_loopback_ram.sv
`default_nettype none
// ============================================================================
// Module   : lb_ram
// Purpose  : Simple dual-port packet buffer. One synchronous write port and
//            one combinational read port, so a word written on one edge is
//            readable during the following cycle.
// Ports    : clk          - clock
//            we/waddr/wdata - write port
//            raddr/rdata  - read port (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module lb_ram
    import udp_lb_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/udp_rx_loopback.sv
`default_nettype none
// ============================================================================
// Module   : udp_rx_loopback
// Purpose  : Buffers received UDP payload packets and, once a packet has
//            arrived intact, replays it on the user transmit stream. Packets
//            that do not fit (buffer full or longer than MAX_WORDS) or that
//            are cut short by a new sop are dropped.
// Ports    : clk, rst_n (sync, active-low)
//            rx_data/rx_vld/rx_sop/rx_eop/rx_mty - receive stream, no backpressure
//            tx_data/tx_vld/tx_sop/tx_eop/tx_mty/tx_rdy - transmit stream
//            pkt_cnt  - packets committed (wraps)
//            drop_cnt - packets dropped (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module udp_rx_loopback #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_vld,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic              rx_mty,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_vld,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              tx_mty,
    input  logic              tx_rdy,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);
    import udp_lb_pkg::*;

    localparam int DEPTH = 2**ADDR_W;
    localparam int EW    = entry_width(DATA_W);
    localparam int CNT_W = $clog2(MAX_WORDS + 1) + 1;

    localparam logic [ADDR_W:0] c_ptr_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_ptr_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    wr_state_e        r_wstate, w_wstate_nxt;
    logic [ADDR_W:0]  r_wr_ptr, r_wr_commit, r_rd_ptr;
    logic [ADDR_W:0]  w_wr_ptr_nxt, w_wr_commit_nxt, w_base;
    logic [CNT_W-1:0] r_wcnt, w_wcnt_nxt, w_base_cnt;
    logic             w_start, w_abort, w_take, w_full, w_too_long, w_ovf;
    logic             w_we, w_pkt_inc;
    logic [1:0]       w_drop_add;
    logic             r_sop_pend;
    logic [EW-1:0]    w_wdata, w_rdata;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    // A sop always (re)starts a packet at the last commit point; an abort
    // therefore needs no separate rewind step.
    assign w_start    = rx_vld & rx_sop;
    assign w_abort    = w_start & (r_wstate == W_RECV);
    assign w_take     = rx_vld & (w_start | (r_wstate == W_RECV));
    assign w_base     = w_start ? r_wr_commit : r_wr_ptr;
    assign w_base_cnt = w_start ? '0 : r_wcnt;
    // Occupancy uses this cycle's rd_ptr; a concurrent read frees space
    // only from the next cycle on.
    assign w_full     = (w_base - r_rd_ptr) == c_ptr_depth;
    assign w_too_long = (int'(w_base_cnt) + 1) > MAX_WORDS;
    assign w_ovf      = w_take & (w_full | w_too_long);
    assign w_drop_add = {1'b0, w_abort} + {1'b0, w_ovf};
    assign w_wdata    = {rx_eop, rx_eop & rx_mty, rx_data};

    always_comb begin
        w_wstate_nxt    = r_wstate;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_wr_commit_nxt = r_wr_commit;
        w_wcnt_nxt      = r_wcnt;
        w_we            = 1'b0;
        w_pkt_inc       = 1'b0;
        if (w_take) begin
            if (w_ovf) begin
                w_wr_ptr_nxt = r_wr_commit;
                w_wstate_nxt = rx_eop ? W_IDLE : W_DROP;
            end else begin
                w_we         = 1'b1;
                w_wr_ptr_nxt = w_base + c_ptr_one;
                w_wcnt_nxt   = w_base_cnt + c_cnt_one;
                if (rx_eop) begin
                    w_wr_commit_nxt = w_base + c_ptr_one;
                    w_pkt_inc       = 1'b1;
                    w_wstate_nxt    = W_IDLE;
                end else begin
                    w_wstate_nxt = W_RECV;
                end
            end
        end else if (rx_vld && rx_eop && (r_wstate == W_DROP)) begin
            w_wstate_nxt = W_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate    <= W_IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_wcnt      <= '0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
        end else begin
            r_wstate    <= w_wstate_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_commit <= w_wr_commit_nxt;
            r_wcnt      <= w_wcnt_nxt;
            pkt_cnt     <= pkt_cnt + {15'b0, w_pkt_inc};
            drop_cnt    <= drop_cnt + {14'b0, w_drop_add};
        end
    end

    lb_ram #(
        .WIDTH (EW),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_base[ADDR_W-1:0]),
        .wdata (w_wdata),
        .raddr (r_rd_ptr[ADDR_W-1:0]),
        .rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Read side: one-word output register, refilled whenever it is empty
    // or being consumed. Only committed words (below wr_commit) are read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data    <= '0;
            tx_vld     <= 1'b0;
            tx_sop     <= 1'b0;
            tx_eop     <= 1'b0;
            tx_mty     <= 1'b0;
            r_rd_ptr   <= '0;
            r_sop_pend <= 1'b1;
        end else if (!tx_vld || tx_rdy) begin
            if (r_rd_ptr != r_wr_commit) begin
                tx_data    <= w_rdata[DATA_W-1:0];
                tx_eop     <= w_rdata[EW-1];
                tx_mty     <= w_rdata[EW-2];
                tx_sop     <= r_sop_pend;
                tx_vld     <= 1'b1;
                r_sop_pend <= w_rdata[EW-1];
                r_rd_ptr   <= r_rd_ptr + c_ptr_one;
            end else begin
                tx_vld <= 1'b0;
                tx_sop <= 1'b0;
                tx_eop <= 1'b0;
                tx_mty <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_loopback.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_rx_loopback
// Purpose  : Self-checking bench for udp_rx_loopback. Packets are described
//            as whole objects (length, truncated or not); their fate (echo or
//            drop) and the expected echoed words follow from the packet
//            rules, and a monitor compares every transmit handshake and every
//            stalled cycle against that expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_rx_loopback;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int MAXW = 12;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic          mty;
    } word_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_vld  = 1'b0;
    logic          rx_sop  = 1'b0;
    logic          rx_eop  = 1'b0;
    logic          rx_mty  = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_vld, tx_sop, tx_eop, tx_mty;
    logic          tx_rdy  = 1'b0;
    logic [15:0]   pkt_cnt, drop_cnt;

    int    n_tests  = 0;
    int    n_fail   = 0;
    word_t exp_q[$];
    int    exp_pkt  = 0;
    int    exp_drop = 0;
    bit    rdy_random = 1'b0;
    logic  rdy_force  = 1'b1;
    bit    hold_pend  = 1'b0;
    word_t hold_word;
    word_t mon_cur, mon_exp;

    udp_rx_loopback #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .rx_sop   (rx_sop),
        .rx_eop   (rx_eop),
        .rx_mty   (rx_mty),
        .tx_data  (tx_data),
        .tx_vld   (tx_vld),
        .tx_sop   (tx_sop),
        .tx_eop   (tx_eop),
        .tx_mty   (tx_mty),
        .tx_rdy   (tx_rdy),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // tx_rdy updates 2 time units after each rising edge, after stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            tx_rdy = rdy_random ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Transmit monitor: scoreboard on handshakes, stability while stalled.
    always @(negedge clk) begin
        mon_cur = '{data: tx_data, sop: tx_sop, eop: tx_eop, mty: tx_mty};
        if (rst_n && hold_pend)
            check("tx_hold", 32'({tx_vld, mon_cur}), 32'({1'b1, hold_word}));
        if (rst_n && tx_vld && tx_rdy) begin
            check("tx_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("tx_word", 32'(mon_cur), 32'(mon_exp));
            end
        end
        hold_pend = rst_n && tx_vld && !tx_rdy;
        hold_word = mon_cur;
    end

    task automatic drive(input logic v, input logic s, input logic e, input logic m,
                         input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        rx_vld  = v;
        rx_sop  = s;
        rx_eop  = e;
        rx_mty  = m;
        rx_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // A packet is echoed unless it is truncated, longer than MAXW, or the
    // caller knows it cannot fit (force_drop).
    task automatic send_pkt(input int len, input bit trunc, input bit rnd,
                            input logic [DW-1:0] base, input logic [DW-1:0] step,
                            input logic mty, input bit gaps, input bit tail_idle,
                            input bit force_drop);
        word_t         pq[$];
        logic [DW-1:0] d;
        logic          last;
        logic          m;
        d = base;
        for (int i = 0; i < len; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if (rnd) d = DW'($urandom);
            last = (i == len - 1) && !trunc;
            m    = last ? mty : 1'($urandom_range(0, 1));
            drive(1'b1, i == 0, last, m, d);
            pq.push_back('{data: d, sop: (i == 0), eop: last, mty: last & mty});
            if (!rnd) d = d + step;
        end
        if (trunc || len > MAXW || force_drop) begin
            exp_drop++;
        end else begin
            foreach (pq[k]) exp_q.push_back(pq[k]);
            exp_pkt++;
        end
        if (tail_idle) idle(1);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(tx_vld), 32'd0);
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        rx_vld = 1'b0;
        rx_sop = 1'b0;
        rx_eop = 1'b0;
        exp_q.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        @(posedge clk);
        #1;
        check("rst_tx", 32'({tx_vld, tx_sop, tx_eop, tx_mty, tx_data}), 32'd0);
        check("rst_cnt", {pkt_cnt, drop_cnt}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t bp_word;
        bit    found;
        int    len;
        bit    tr;

        rdy_force = 1'b1;
        do_reset();

        // Pass-through of a fixed 4-word packet.
        send_pkt(4, 0, 0, 16'h1111, 16'h1111, 1'b1, 0, 1, 0);
        wait_drain("pass_drain");
        check_cnts("pass");

        // Backpressure: stall 5 cycles once the first word is presented.
        rdy_force = 1'b0;
        send_pkt(3, 0, 1, '0, '0, 1'b0, 0, 1, 0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = tx_vld;
        end
        check("bp_vld", 32'(found), 32'd1);
        bp_word = '{data: tx_data, sop: tx_sop, eop: tx_eop, mty: tx_mty};
        repeat (5) @(negedge clk);
        check("bp_hold", 32'({tx_vld, tx_data, tx_sop, tx_eop, tx_mty}), 32'({1'b1, bp_word}));
        rdy_force = 1'b1;
        wait_drain("bp_drain");

        // Over-length packet with receiver stalled: nothing emitted.
        rdy_force = 1'b0;
        do_reset();
        send_pkt(20, 0, 1, '0, '0, 1'b1, 0, 1, 0);
        idle(3);
        check("ovf_vld", 32'(tx_vld), 32'd0);
        check_cnts("ovf");
        rdy_force = 1'b1;
        send_pkt(4, 0, 1, '0, '0, 1'b1, 0, 1, 0);
        wait_drain("ovf_echo");
        check_cnts("ovf_echo");
        send_pkt(MAXW, 0, 1, '0, '0, 1'b0, 0, 1, 0);
        wait_drain("maxlen");
        check_cnts("maxlen");

        // Full buffer: 15 words committed, one parked in the output stage,
        // so the 4-word packet fits only 2 words and is dropped.
        rdy_force = 1'b0;
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(5, 0, 1, '0, '0, 1'b1, 0, 1, 0);
        send_pkt(4, 0, 1, '0, '0, 1'b1, 0, 1, 1);
        send_pkt(2, 0, 1, '0, '0, 1'b1, 0, 1, 0);
        idle(2);
        check_cnts("full");
        rdy_force = 1'b1;
        wait_drain("full_drain");

        // Abort by a new sop.
        send_pkt(2, 1, 1, '0, '0, 1'b0, 0, 0, 0);
        send_pkt(3, 0, 1, '0, '0, 1'b1, 0, 1, 0);
        wait_drain("abort");
        check_cnts("abort");

        // Single-word packet followed back-to-back by a 2-word packet.
        send_pkt(1, 0, 0, 16'hABCD, '0, 1'b1, 0, 0, 0);
        send_pkt(2, 0, 1, '0, '0, 1'b0, 0, 1, 0);
        wait_drain("single");
        check_cnts("single");

        // Reset while word 2 of 5 is on the transmit port.
        send_pkt(5, 0, 1, '0, '0, 1'b1, 0, 1, 0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            found = tx_vld && tx_sop;
        end
        check("rst_mid_found", 32'(found), 32'd1);
        do_reset();
        send_pkt(3, 0, 1, '0, '0, 1'b1, 0, 1, 0);
        wait_drain("post_rst");
        check_cnts("post_rst");

        // Randomised packets, gaps, junk words and random tx_rdy.
        rdy_random = 1'b1;
        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(1, 14);
            tr  = ($urandom_range(0, 5) == 0);
            send_pkt(len, tr, 1, '0, '0, 1'($urandom_range(0, 1)), 1, 1, 0);
            if (!tr) begin
                if ($urandom_range(0, 2) == 0) begin
                    drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, DW'($urandom));
                    idle(1);
                end
                wait_drain("rand_drain");
            end
        end
        send_pkt(3, 0, 1, '0, '0, 1'b1, 0, 1, 0);
        wait_drain("rand_final");
        check_cnts("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
